// File: rtl/dec_huff_pkg.sv
// Shared constants, state encodings and helpers for the DecHuff symbol sequencer.
package dec_huff_pkg;

    localparam int unsigned PEEK_BITS = 16;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned LEN_W     = 5;
    localparam int unsigned LEN_LSB   = 8;
    localparam int unsigned SYM_W     = LEN_W + IDX_W;

    localparam logic [16:0] INVALID_MAX = 17'h10000;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_REQ  = 4'd1;
    localparam logic [3:0] ST_WAIT = 4'd2;
    localparam logic [3:0] ST_SRCH = 4'd3;
    localparam logic [3:0] ST_ADV  = 4'd4;
    localparam logic [3:0] ST_EMIT = 4'd5;
    localparam logic [3:0] ST_ERR  = 4'd6;
    localparam logic [3:0] ST_DSYM = 4'd7;
    localparam logic [3:0] ST_DADV = 4'd8;
    localparam logic [3:0] ST_DREQ = 4'd9;
    localparam logic [3:0] ST_HALT = 4'd10;

    typedef struct packed {
        logic [15:0] mincode;
        logic [16:0] maxcode;
        logic [7:0]  valptr;
    } len_entry_t;

    // Top L bits of the peek window, right-aligned (len is 1..16).
    function automatic logic [15:0] peek_code(input logic [15:0] peek, input logic [4:0] len);
        return peek >> (5'd16 - len);
    endfunction

    // Symbol index wraps mod 256.
    function automatic logic [7:0] sym_index(input logic [7:0] valptr, input logic [15:0] code,
                                             input logic [15:0] mincode);
        logic [15:0] sum;
        sum = {8'b0, valptr} + code - mincode;
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dec_huff_sym_sequencer_if.sv
// Token streams between the symbol sequencer (master) and the DecHuff page / consumer (slave).
interface dec_huff_sym_sequencer_if;

    logic [7:0]  reqSize_d;
    logic        reqSize_e;
    logic        reqSize_v;
    logic        reqSize_b;

    logic [7:0]  advance_d;
    logic        advance_e;
    logic        advance_v;
    logic        advance_b;

    logic [15:0] parsedToken_d;
    logic        parsedToken_e;
    logic        parsedToken_v;
    logic        parsedToken_b;

    logic [12:0] sym_d;
    logic        sym_e;
    logic        sym_v;
    logic        sym_b;

    modport master (
        output reqSize_d, reqSize_e, reqSize_v,
        input  reqSize_b,
        output advance_d, advance_e, advance_v,
        input  advance_b,
        input  parsedToken_d, parsedToken_e, parsedToken_v,
        output parsedToken_b,
        output sym_d, sym_e, sym_v,
        input  sym_b
    );

    modport slave (
        input  reqSize_d, reqSize_e, reqSize_v,
        output reqSize_b,
        input  advance_d, advance_e, advance_v,
        output advance_b,
        output parsedToken_d, parsedToken_e, parsedToken_v,
        input  parsedToken_b,
        input  sym_d, sym_e, sym_v,
        output sym_b
    );

endinterface

// File: rtl/dec_huff_len_table.sv
// Per-length canonical-Huffman table: 16 entries, one write port, one combinational read port.
module dec_huff_len_table
    import dec_huff_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] wr_sel,
    input  len_entry_t wr_entry,
    input  logic [3:0] rd_sel,
    output len_entry_t rd_entry
);

    len_entry_t tbl [16];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                tbl[i] <= '{mincode: 16'h0, maxcode: INVALID_MAX, valptr: 8'h0};
            end
        end else if (we) begin
            tbl[wr_sel] <= wr_entry;
        end
    end

    assign rd_entry = tbl[rd_sel];

endmodule

// File: rtl/dec_huff_sym_sequencer.sv
// Drives the DecHuff page peek/advance loop and emits one decoded Huffman symbol per iteration.
module dec_huff_sym_sequencer
    import dec_huff_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       go,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_len,
    input  logic [15:0]                cfg_mincode,
    input  logic [16:0]                cfg_maxcode,
    input  logic [7:0]                 cfg_valptr,
    output logic                       cfg_busy,
    dec_huff_sym_sequencer_if.master   dh,
    output logic                       err
);

    logic [3:0]  state_q, state_d;
    logic [15:0] peek_q, peek_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic        err_q, err_d;

    len_entry_t  wr_entry;
    len_entry_t  rd_entry;
    logic [3:0]  rd_sel;
    logic [15:0] code;
    logic        hit;

    assign wr_entry = '{mincode: cfg_mincode, maxcode: cfg_maxcode, valptr: cfg_valptr};
    assign rd_sel   = len_q[3:0] - 4'd1;

    dec_huff_len_table u_len_table (
        .clock    (clock),
        .reset    (reset),
        .we       (cfg_we && (state_q == ST_IDLE)),
        .wr_sel   (cfg_len),
        .wr_entry (wr_entry),
        .rd_sel   (rd_sel),
        .rd_entry (rd_entry)
    );

    // Canonical codes: a valid length matches as soon as the code does not exceed its maxcode.
    assign code = peek_code(peek_q, len_q);
    assign hit  = !rd_entry.maxcode[16] && ({1'b0, code} <= rd_entry.maxcode);

    always_comb begin
        state_d = state_q;
        peek_d  = peek_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (go) state_d = ST_REQ;
            ST_REQ:  if (!dh.reqSize_b) state_d = ST_WAIT;
            ST_WAIT: begin
                if (dh.parsedToken_v) begin
                    if (dh.parsedToken_e) begin
                        state_d = ST_DSYM;
                    end else begin
                        peek_d  = dh.parsedToken_d;
                        len_d   = 5'd1;
                        state_d = ST_SRCH;
                    end
                end
            end
            ST_SRCH: begin
                if (hit) begin
                    idx_d   = sym_index(rd_entry.valptr, code, rd_entry.mincode);
                    state_d = ST_ADV;
                end else if (len_q == 5'd16) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    len_d = len_q + 5'd1;
                end
            end
            ST_ADV:  if (!dh.advance_b) state_d = ST_EMIT;
            ST_EMIT: if (!dh.sym_b) state_d = go ? ST_REQ : ST_IDLE;
            ST_ERR:  if (!dh.sym_b) state_d = ST_HALT;
            ST_DSYM: if (!dh.sym_b) state_d = ST_DADV;
            ST_DADV: if (!dh.advance_b) state_d = ST_DREQ;
            ST_DREQ: if (!dh.reqSize_b) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            peek_q  <= 16'h0;
            len_q   <= 5'd1;
            idx_q   <= 8'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            peek_q  <= peek_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        dh.reqSize_d     = 8'(PEEK_BITS);
        dh.reqSize_v     = (state_q == ST_REQ) || (state_q == ST_DREQ);
        dh.reqSize_e     = (state_q == ST_DREQ);
        dh.advance_d     = {3'b000, len_q};
        dh.advance_v     = (state_q == ST_ADV) || (state_q == ST_DADV);
        dh.advance_e     = (state_q == ST_DADV);
        dh.sym_d         = {len_q, idx_q};
        dh.sym_v         = (state_q == ST_EMIT) || (state_q == ST_ERR) || (state_q == ST_DSYM);
        dh.sym_e         = (state_q == ST_ERR) || (state_q == ST_DSYM);
        dh.parsedToken_b = (state_q != ST_WAIT);
        cfg_busy         = (state_q != ST_IDLE);
        err              = err_q;
    end

endmodule

// File: tb/tb_dec_huff_sym_sequencer.sv
// Directed bench for dec_huff_sym_sequencer: decode, backpressure, error, EOS and reset paths.
module tb_dec_huff_sym_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_len = 4'h0;
    logic [15:0] cfg_mincode = 16'h0;
    logic [16:0] cfg_maxcode = 17'h0;
    logic [7:0]  cfg_valptr = 8'h0;
    logic        cfg_busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req   = 0;
    int n_adv   = 0;
    int n_sym   = 0;

    dec_huff_sym_sequencer_if dh ();

    dec_huff_sym_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .go          (go),
        .cfg_we      (cfg_we),
        .cfg_len     (cfg_len),
        .cfg_mincode (cfg_mincode),
        .cfg_maxcode (cfg_maxcode),
        .cfg_valptr  (cfg_valptr),
        .cfg_busy    (cfg_busy),
        .dh          (dh),
        .err         (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) begin
            if (dh.reqSize_v && !dh.reqSize_b) n_req++;
            if (dh.advance_v && !dh.advance_b) n_adv++;
            if (dh.sym_v && !dh.sym_b) n_sym++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic vsel(input int which);
        case (which)
            0:       return dh.reqSize_v;
            1:       return !dh.parsedToken_b;
            2:       return dh.advance_v;
            default: return dh.sym_v;
        endcase
    endfunction

    // Counts negedges (current one first) until the selected valid is seen, bounded.
    task automatic wait_valid(input int which, input string tag, output int cnt);
        cnt = 0;
        while (!vsel(which) && cnt < 64) begin
            cnt++;
            @(negedge clock);
        end
        chk(tag, 32'(vsel(which)), 32'd1);
    endtask

    task automatic cfg_write(input logic [3:0] len_m1, input logic [15:0] mn,
                             input logic [16:0] mx, input logic [7:0] vp);
        cfg_len = len_m1; cfg_mincode = mn; cfg_maxcode = mx; cfg_valptr = vp;
        cfg_we = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic send_token(input logic [15:0] d, input logic e);
        dh.parsedToken_d = d;
        dh.parsedToken_e = e;
        dh.parsedToken_v = 1'b1;
        @(negedge clock);
        dh.parsedToken_v = 1'b0;
        dh.parsedToken_e = 1'b0;
    endtask

    task automatic req_to_wait(input string tag);
        int c;
        wait_valid(0, {tag, "_req"}, c);
        @(negedge clock);
        wait_valid(1, {tag, "_wait"}, c);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s_req, s_adv, s_sym;
        dh.reqSize_b = 1'b0;
        dh.advance_b = 1'b0;
        dh.sym_b = 1'b0;
        dh.parsedToken_v = 1'b0;
        dh.parsedToken_e = 1'b0;
        dh.parsedToken_d = 16'h0;

        repeat (3) @(negedge clock);
        chk("rst_req_v", 32'(dh.reqSize_v), 0);
        chk("rst_adv_v", 32'(dh.advance_v), 0);
        chk("rst_sym_v", 32'(dh.sym_v), 0);
        chk("rst_e", 32'({dh.reqSize_e, dh.advance_e, dh.sym_e}), 0);
        chk("rst_pt_b", 32'(dh.parsedToken_b), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(cfg_busy), 0);
        reset = 1'b1;

        // 1: load L=2, then L=3 together with go; peek 4000 decodes to {2,1}
        cfg_write(4'd1, 16'd0, 17'd1, 8'd0);
        cfg_len = 4'd2; cfg_mincode = 16'd4; cfg_maxcode = 17'd6; cfg_valptr = 8'd2;
        cfg_we = 1'b1;
        go = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0;
        chk("t1_busy", 32'(cfg_busy), 1);
        chk("t1_req_v", 32'(dh.reqSize_v), 1);
        chk("t1_req_d", 32'(dh.reqSize_d), 16);
        @(negedge clock);
        wait_valid(1, "t1_wait", c);
        send_token(16'h4000, 1'b0);
        wait_valid(2, "t1_adv_v", c);
        chk("t1_srch_cycles", 32'(c), 2);
        chk("t1_adv_d", 32'(dh.advance_d), 2);
        @(negedge clock);
        wait_valid(3, "t1_sym_v", c);
        chk("t1_sym_d", 32'(dh.sym_d), 32'h201);
        chk("t1_sym_e", 32'(dh.sym_e), 0);
        @(negedge clock);

        // 2+4: peek C000 with advance/sym backpressure; go drops before EMIT completes
        dh.advance_b = 1'b1;
        dh.sym_b = 1'b1;
        req_to_wait("t2");
        send_token(16'hC000, 1'b0);
        wait_valid(2, "t2_adv_v", c);
        chk("t2_srch_cycles", 32'(c), 3);
        chk("t2_adv_d", 32'(dh.advance_d), 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_adv_hold", 32'({dh.advance_v, dh.advance_d}), 32'h103);
        end
        dh.advance_b = 1'b0;
        @(negedge clock);
        wait_valid(3, "t2_sym_v", c);
        chk("t2_sym_d", 32'(dh.sym_d), 32'h304);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_sym_hold", 32'({dh.sym_v, dh.sym_d}), 32'h2304);
        end
        go = 1'b0;
        dh.sym_b = 1'b0;
        @(negedge clock);
        chk("t2_idle_busy", 32'(cfg_busy), 0);
        chk("t2_idle_req_v", 32'(dh.reqSize_v), 0);
        chk("t4_adv_count", 32'(n_adv), 2);
        chk("t4_sym_count", 32'(n_sym), 2);
        chk("t4_req_count", 32'(n_req), 2);

        // 3: busy write of L=1 must be ignored; E000 matches nothing -> ERR
        go = 1'b1;
        wait_valid(0, "t3_req", c);
        cfg_write(4'd0, 16'd0, 17'd1, 8'd9);
        wait_valid(1, "t3_wait", c);
        send_token(16'hE000, 1'b0);
        wait_valid(3, "t3_sym_v", c);
        chk("t3_srch_cycles", 32'(c), 16);
        chk("t3_err", 32'(err), 1);
        chk("t3_sym_e", 32'(dh.sym_e), 1);
        chk("t3_no_adv", 32'(n_adv), 2);
        @(negedge clock);
        repeat (4) @(negedge clock);
        chk("t3_done_quiet", 32'({dh.reqSize_v, dh.advance_v, dh.sym_v}), 0);
        chk("t3_err_sticky", 32'(err), 1);

        // 5: EOS in WAIT forwards sym, advance, reqSize end tokens in order
        go = 1'b0;
        reset_pulse();
        chk("t5_err_cleared", 32'(err), 0);
        go = 1'b1;
        req_to_wait("t5");
        s_req = n_req; s_adv = n_adv; s_sym = n_sym;
        send_token(16'h0, 1'b1);
        wait_valid(3, "t5_sym_v", c);
        chk("t5_sym_e", 32'(dh.sym_e), 1);
        @(negedge clock);
        chk("t5_adv", 32'({dh.advance_v, dh.advance_e, dh.sym_v}), 32'h6);
        @(negedge clock);
        chk("t5_req", 32'({dh.reqSize_v, dh.reqSize_e, dh.advance_v}), 32'h6);
        repeat (4) @(negedge clock);
        chk("t5_quiet", 32'({dh.reqSize_v, dh.advance_v, dh.sym_v}), 0);
        chk("t5_counts", 32'({8'(n_req - s_req), 8'(n_adv - s_adv), 8'(n_sym - s_sym)}),
            32'h010101);
        chk("t5_err", 32'(err), 0);

        // 6: reset during SRCH aborts and clears the table
        go = 1'b0;
        reset_pulse();
        cfg_write(4'd1, 16'd0, 17'd1, 8'd0);
        cfg_write(4'd2, 16'd4, 17'd6, 8'd2);
        go = 1'b1;
        req_to_wait("t6");
        send_token(16'h4000, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("t6_v", 32'({dh.reqSize_v, dh.advance_v, dh.sym_v}), 0);
        chk("t6_pt_b", 32'(dh.parsedToken_b), 1);
        chk("t6_busy", 32'(cfg_busy), 0);
        reset = 1'b1;
        s_adv = n_adv;
        req_to_wait("t6b");
        send_token(16'h4000, 1'b0);
        wait_valid(3, "t6_sym_v", c);
        chk("t6_tbl_invalid", 32'(c), 16);
        chk("t6_err_sym_e", 32'({err, dh.sym_e}), 32'h3);
        chk("t6_no_adv", 32'(n_adv - s_adv), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
